// File: rtl/symbol_strobe_sched.sv
// symbol_strobe_sched
//   Runtime-programmable strobe scheduler for the BPSK TX path. Emits a one-cycle
//   sample enable every cfg_div clocks (minimum 2) and a symbol enable on every
//   SPS-th sample. One bit per symbol is pulled from upstream through a one-bit
//   prefetch buffer, and exactly frame_len symbols are run per accepted start.
//   The strobes are enables for logic clocked by i_clk, never clocks themselves.
//
// Ports
//   i_clk      system clock
//   rst        synchronous reset, active-high
//   start      frame request, accepted only in IDLE with frame_len != 0
//   cfg_div    sample period in clocks, latched on accepted start (<2 acts as 2)
//   frame_len  symbols per frame, latched on accepted start
//   s_bit      upstream data bit
//   s_valid    upstream bit valid
//   s_ready    bit accepted when s_valid & s_ready
//   o_smp_stb  one-cycle sample enable
//   o_sym_stb  one-cycle symbol enable, only ever high together with o_smp_stb
//   o_bit      current symbol bit, new value visible in the o_sym_stb cycle
//   busy       high while a frame is being primed or run (including done cycle)
//   done       one-cycle pulse at frame end
//   underrun   sticky, a symbol started with the buffer empty
module symbol_strobe_sched #(
    parameter int DIV_W = 16,
    parameter int LEN_W = 12,
    parameter int SPS   = 8
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             s_bit,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             o_smp_stb,
    output logic             o_sym_stb,
    output logic             o_bit,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int              KW     = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [KW-1:0]   K_LAST = KW'(SPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_m1;    // latched sample period minus one
    logic [LEN_W-1:0] r_len;
    logic [DIV_W-1:0] r_cnt;       // clock count within a sample period
    logic [KW-1:0]    r_k;         // sample index within a symbol
    logic [LEN_W-1:0] r_nsym;      // symbols started so far
    logic [LEN_W-1:0] r_fetched;   // bits taken from upstream this frame
    logic             r_buf;
    logic             r_buf_full;
    logic             r_bit;
    logic             r_und;

    logic w_busy;
    logic w_due;
    logic w_sym_due;
    logic w_end;
    logic w_sym;
    logic w_ready;
    logic w_take;
    logic w_sym_bit;

    assign w_busy    = (r_state != IDLE);
    assign w_due     = (r_state == RUN) && (r_cnt == '0);
    assign w_sym_due = w_due && (r_k == '0);
    // The strobe that would start symbol len is the frame-end slot instead.
    assign w_end     = w_sym_due && (r_nsym == r_len);
    assign w_sym     = w_sym_due && !w_end;
    assign w_ready   = w_busy && !r_buf_full && (r_fetched < r_len);
    assign w_take    = w_ready && s_valid;
    // An empty buffer yields 0; no late bit is ever substituted.
    assign w_sym_bit = r_buf_full & r_buf;

    assign s_ready   = w_ready;
    assign o_smp_stb = w_due && !w_end;
    assign o_sym_stb = w_sym;
    assign o_bit     = w_sym ? w_sym_bit : r_bit;
    assign busy      = w_busy;
    assign done      = w_end;
    // Show the underrun in the very symbol cycle it occurs, then hold it.
    assign underrun  = r_und || (w_sym && !r_buf_full);

    always_ff @(posedge i_clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_div_m1   <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_k        <= '0;
            r_nsym     <= '0;
            r_fetched  <= '0;
            r_buf      <= 1'b0;
            r_buf_full <= 1'b0;
            r_bit      <= 1'b0;
            r_und      <= 1'b0;
        end else begin
            if (w_take) begin
                r_buf      <= s_bit;
                r_buf_full <= 1'b1;
                r_fetched  <= r_fetched + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start && (frame_len != '0)) begin
                        r_state    <= PRIME;
                        r_div_m1   <= (cfg_div < DIV_W'(2)) ? DIV_W'(1) : (cfg_div - 1'b1);
                        r_len      <= frame_len;
                        r_und      <= 1'b0;
                        r_fetched  <= '0;
                        r_buf_full <= 1'b0;
                        r_cnt      <= '0;
                        r_k        <= '0;
                        r_nsym     <= '0;
                    end
                end

                PRIME: begin
                    if (r_buf_full) begin
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    r_cnt <= (r_cnt == r_div_m1) ? '0 : (r_cnt + 1'b1);
                    if (w_end) begin
                        // Drop anything fetched after an underrun so the next
                        // frame never starts with a stale bit.
                        r_state    <= IDLE;
                        r_bit      <= 1'b0;
                        r_buf_full <= 1'b0;
                    end else if (w_due) begin
                        r_k <= (r_k == K_LAST) ? '0 : (r_k + 1'b1);
                        if (r_k == '0) begin
                            r_nsym     <= r_nsym + 1'b1;
                            r_bit      <= w_sym_bit;
                            r_buf_full <= 1'b0;
                            if (!r_buf_full) begin
                                r_und <= 1'b1;
                            end
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
